// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port between NrHosts hosts.
// Stalled requests stay locked to their host, and an ID FIFO routes in-order responses back to the issuing host.
module bus_host_arbiter #(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NrHosts-1:0]               host_req_i,
  output logic [NrHosts-1:0]               host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0]  host_addr_i,
  input  logic [NrHosts-1:0]               host_we_i,
  input  logic [NrHosts*4-1:0]             host_be_i,
  input  logic [NrHosts*DataWidth-1:0]     host_wdata_i,
  output logic [NrHosts-1:0]               host_rvalid_o,
  output logic [DataWidth-1:0]             host_rdata_o,
  output logic                             host_err_o,
  output logic                             dev_req_o,
  input  logic                             dev_gnt_i,
  output logic [AddressWidth-1:0]          dev_addr_o,
  output logic                             dev_we_o,
  output logic [3:0]                       dev_be_o,
  output logic [DataWidth-1:0]             dev_wdata_o,
  input  logic                             dev_rvalid_i,
  input  logic [DataWidth-1:0]             dev_rdata_i,
  input  logic                             dev_err_i,
  output logic                             unexp_rsp_o
);

  localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NrHosts - 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  logic [IdxW-1:0] rr_ptr;
  logic [IdxW-1:0] lock_idx;
  logic            lock_valid;
  logic            lock_hold;
  logic [IdxW-1:0] sel;
  logic [IdxW-1:0] sel_next;
  logic            any_req;
  logic            issue_ok;
  logic            grant;
  logic            pop;

  logic [IdxW-1:0] id_fifo [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic [IdxW-1:0] head;
  logic            unexp_rsp_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // A lock only holds while its host keeps requesting; a dropped request falls back to round-robin.
  assign lock_hold = lock_valid & host_req_i[lock_idx];
  assign any_req   = |host_req_i;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    int   cand;
    logic found;
    sel   = rr_ptr;
    cand  = 0;
    found = 1'b0;
    if (lock_hold) begin
      sel = lock_idx;
    end else begin
      for (int i = 0; i < NrHosts; i++) begin
        cand = int'(rr_ptr) + i;
        if (cand >= NrHosts) cand = cand - NrHosts;
        if (!found && host_req_i[cand]) begin
          sel   = IdxW'(cand);
          found = 1'b1;
        end
      end
    end
  end

  assign sel_next = (sel == LastIdx) ? '0 : sel + 1'b1;

  // Full gating looks only at the registered count; a pop this cycle frees a slot next cycle.
  assign issue_ok  = !rst_i && any_req && (count < CntMax);
  assign dev_req_o = issue_ok;
  assign grant     = issue_ok & dev_gnt_i;

  assign dev_addr_o  = host_addr_i[int'(sel)*AddressWidth +: AddressWidth];
  assign dev_we_o    = host_we_i[sel];
  assign dev_be_o    = host_be_i[int'(sel)*4 +: 4];
  assign dev_wdata_o = host_wdata_i[int'(sel)*DataWidth +: DataWidth];

  always_comb begin
    host_gnt_o      = '0;
    host_gnt_o[sel] = grant;
  end

  assign pop  = dev_rvalid_i && (count != '0);
  assign head = id_fifo[rd_ptr];

  always_comb begin
    host_rvalid_o       = '0;
    host_rvalid_o[head] = pop;
  end

  assign host_rdata_o = dev_rdata_i;
  assign host_err_o   = dev_err_i;
  assign unexp_rsp_o  = unexp_rsp_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      lock_valid  <= 1'b0;
      lock_idx    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      unexp_rsp_q <= 1'b0;
    end else begin
      if (grant) begin
        rr_ptr     <= sel_next;
        lock_valid <= 1'b0;
      end else if (issue_ok) begin
        lock_valid <= 1'b1;
        lock_idx   <= sel;
      end else begin
        lock_valid <= 1'b0;
      end

      if (grant) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);

      case ({grant, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (dev_rvalid_i && (count == '0)) unexp_rsp_q <= 1'b1;
    end
  end

  // NOTE: the ID storage has no reset; an entry is only read after it was written, and reset clears count.
  always_ff @(posedge clk_i) begin
    if (grant) id_fifo[wr_ptr] <= sel;
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Self-checking bench for bus_host_arbiter: vector table plus hand sequences, responses routed through a scoreboard queue.
module tb_bus_host_arbiter;

  logic        clk;
  logic        rst_i;
  logic [1:0]  host_req_i;
  logic [1:0]  host_gnt_o;
  logic [63:0] host_addr_i;
  logic [1:0]  host_we_i;
  logic [7:0]  host_be_i;
  logic [63:0] host_wdata_i;
  logic [1:0]  host_rvalid_o;
  logic [31:0] host_rdata_o;
  logic        host_err_o;
  logic        dev_req_o;
  logic        dev_gnt_i;
  logic [31:0] dev_addr_o;
  logic        dev_we_o;
  logic [3:0]  dev_be_o;
  logic [31:0] dev_wdata_o;
  logic        dev_rvalid_i;
  logic [31:0] dev_rdata_i;
  logic        dev_err_i;
  logic        unexp_rsp_o;

  bus_host_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .host_req_i   (host_req_i),
    .host_gnt_o   (host_gnt_o),
    .host_addr_i  (host_addr_i),
    .host_we_i    (host_we_i),
    .host_be_i    (host_be_i),
    .host_wdata_i (host_wdata_i),
    .host_rvalid_o(host_rvalid_o),
    .host_rdata_o (host_rdata_o),
    .host_err_o   (host_err_o),
    .dev_req_o    (dev_req_o),
    .dev_gnt_i    (dev_gnt_i),
    .dev_addr_o   (dev_addr_o),
    .dev_we_o     (dev_we_o),
    .dev_be_o     (dev_be_o),
    .dev_wdata_o  (dev_wdata_o),
    .dev_rvalid_i (dev_rvalid_i),
    .dev_rdata_i  (dev_rdata_i),
    .dev_err_i    (dev_err_i),
    .unexp_rsp_o  (unexp_rsp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  exp_gnt;
    logic        exp_req;
    int          exp_sel;
    logic        exp_unexp;
    string       name;
  } vec_t;

  logic [31:0] h_addr  [2];
  logic        h_we    [2];
  logic [3:0]  h_be    [2];
  logic [31:0] h_wdata [2];

  int n_checks = 0;
  int n_fail   = 0;
  int sb_q[$];
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic [1:0] req, input logic gnt,
                              input logic rvalid, input logic [31:0] rdata, input logic [1:0] exp_gnt,
                              input logic exp_req, input int exp_sel, input logic exp_unexp,
                              input string name);
    vec_t v;
    v.rst = rst; v.req = req; v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata;
    v.err = rdata[0]; v.exp_gnt = exp_gnt; v.exp_req = exp_req; v.exp_sel = exp_sel;
    v.exp_unexp = exp_unexp; v.name = name;
    return v;
  endfunction

  // Drive one cycle of stimulus, compare mid-cycle, then update the expected-response queue.
  task automatic run_vec(input vec_t v);
    logic [1:0] exp_rv;
    @(posedge clk);
    #1;
    rst_i        = v.rst;
    host_req_i   = v.req;
    dev_gnt_i    = v.gnt;
    dev_rvalid_i = v.rvalid;
    dev_rdata_i  = v.rdata;
    dev_err_i    = v.err;
    exp_rv = 2'b00;
    if (v.rvalid && sb_q.size() > 0) exp_rv = 2'b01 << sb_q[0];
    @(negedge clk);
    check({v.name, ".gnt"}, 32'(host_gnt_o), 32'(v.exp_gnt));
    check({v.name, ".dev_req"}, 32'(dev_req_o), 32'(v.exp_req));
    if (v.exp_sel >= 0) begin
      check({v.name, ".addr"}, dev_addr_o, h_addr[v.exp_sel]);
      check({v.name, ".we_be"}, 32'({dev_we_o, dev_be_o}), 32'({h_we[v.exp_sel], h_be[v.exp_sel]}));
      check({v.name, ".wdata"}, dev_wdata_o, h_wdata[v.exp_sel]);
    end
    check({v.name, ".rvalid"}, 32'(host_rvalid_o), 32'(exp_rv));
    if (exp_rv != 2'b00) begin
      check({v.name, ".rdata"}, host_rdata_o, v.rdata);
      check({v.name, ".err"}, 32'(host_err_o), 32'(v.err));
    end
    check({v.name, ".unexp"}, 32'(unexp_rsp_o), 32'(v.exp_unexp));
    if (v.rvalid && sb_q.size() > 0) void'(sb_q.pop_front());
    if (v.exp_gnt == 2'b01) sb_q.push_back(0);
    if (v.exp_gnt == 2'b10) sb_q.push_back(1);
    if (v.rst) sb_q.delete();
  endtask

  initial begin
    h_addr[0] = 32'h0010_0000; h_addr[1] = 32'h0002_0000;
    h_we[0]   = 1'b0;          h_we[1]   = 1'b1;
    h_be[0]   = 4'hF;          h_be[1]   = 4'h3;
    h_wdata[0] = 32'h1111_1111; h_wdata[1] = 32'h2222_2222;
    host_addr_i  = {h_addr[1], h_addr[0]};
    host_we_i    = {h_we[1], h_we[0]};
    host_be_i    = {h_be[1], h_be[0]};
    host_wdata_i = {h_wdata[1], h_wdata[0]};

    rst_i = 1'b1; host_req_i = '0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0;
    dev_rdata_i = '0; dev_err_i = 1'b0;
    repeat (3) @(posedge clk);

    //          rst  req    gnt   rv    rdata          exp_gnt exp_req sel unexp name
    tbl.push_back(mk(0, 2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1,  0, 1'b0, "single_req"));
    tbl.push_back(mk(0, 2'b00, 1'b0, 1'b1, 32'hDEADBEEF,  2'b00, 1'b0, -1, 1'b0, "single_rsp"));
    tbl.push_back(mk(1, 2'b11, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, -1, 1'b0, "rst_gate"));
    tbl.push_back(mk(0, 2'b11, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1,  0, 1'b0, "fair0"));
    tbl.push_back(mk(0, 2'b11, 1'b1, 1'b1, 32'hA0A0_0001, 2'b10, 1'b1,  1, 1'b0, "fair1_pushpop"));
    tbl.push_back(mk(0, 2'b11, 1'b1, 1'b1, 32'hA0A0_0002, 2'b01, 1'b1,  0, 1'b0, "fair2"));
    tbl.push_back(mk(0, 2'b11, 1'b1, 1'b1, 32'hA0A0_0003, 2'b10, 1'b1,  1, 1'b0, "fair3"));
    tbl.push_back(mk(0, 2'b00, 1'b0, 1'b1, 32'hA0A0_0004, 2'b00, 1'b0, -1, 1'b0, "fair_drain"));
    tbl.push_back(mk(0, 2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1,  0, 1'b0, "full_g1"));
    tbl.push_back(mk(0, 2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1,  0, 1'b0, "full_g2"));
    tbl.push_back(mk(0, 2'b01, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, -1, 1'b0, "full_block"));
    tbl.push_back(mk(0, 2'b01, 1'b1, 1'b1, 32'h5555_0001, 2'b00, 1'b0, -1, 1'b0, "full_pop_noissue"));
    tbl.push_back(mk(0, 2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1,  0, 1'b0, "full_resume"));
    tbl.push_back(mk(0, 2'b00, 1'b0, 1'b1, 32'h5555_0002, 2'b00, 1'b0, -1, 1'b0, "full_rsp1"));
    tbl.push_back(mk(0, 2'b00, 1'b0, 1'b1, 32'h5555_0003, 2'b00, 1'b0, -1, 1'b0, "full_rsp2"));
    tbl.push_back(mk(0, 2'b00, 1'b0, 1'b1, 32'h7777_0000, 2'b00, 1'b0, -1, 1'b0, "unexp_rsp"));
    tbl.push_back(mk(0, 2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, -1, 1'b1, "unexp_set"));
    tbl.push_back(mk(1, 2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, -1, 1'b1, "unexp_rst"));
    tbl.push_back(mk(0, 2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1,  0, 1'b0, "rst_fill1"));
    tbl.push_back(mk(0, 2'b10, 1'b1, 1'b0, 32'h0,         2'b10, 1'b1,  1, 1'b0, "rst_fill2"));
    tbl.push_back(mk(1, 2'b11, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, -1, 1'b0, "rst_mid"));
    tbl.push_back(mk(0, 2'b00, 1'b0, 1'b1, 32'h0BAD_0001, 2'b00, 1'b0, -1, 1'b0, "post_rst_rsp"));
    tbl.push_back(mk(0, 2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, -1, 1'b1, "post_rst_flag"));
    tbl.push_back(mk(0, 2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, -1, 1'b1, "flag_sticky"));

    foreach (tbl[i]) run_vec(tbl[i]);

    // Stall with rr_ptr=1: host1 holds the port for three cycles, then rr_ptr moves to host0.
    run_vec(mk(0, 2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1,  0, 1'b1, "stall_setup"));
    run_vec(mk(0, 2'b00, 1'b0, 1'b1, 32'hC0DE_0001, 2'b00, 1'b0, -1, 1'b1, "stall_setup_rsp"));
    for (int i = 0; i < 3; i++)
      run_vec(mk(0, 2'b11, 1'b0, 1'b0, 32'h0,       2'b00, 1'b1,  1, 1'b1, $sformatf("stall%0d", i)));
    run_vec(mk(0, 2'b11, 1'b1, 1'b0, 32'h0,         2'b10, 1'b1,  1, 1'b1, "stall_grant"));
    run_vec(mk(0, 2'b11, 1'b1, 1'b1, 32'hC0DE_0002, 2'b01, 1'b1,  0, 1'b1, "stall_rr_next"));
    run_vec(mk(0, 2'b00, 1'b0, 1'b1, 32'hC0DE_0003, 2'b00, 1'b0, -1, 1'b1, "stall_drain"));

    // Locked host0 keeps the port even though round-robin would now prefer host1.
    run_vec(mk(0, 2'b01, 1'b0, 1'b0, 32'h0,         2'b00, 1'b1,  0, 1'b1, "lock_set"));
    run_vec(mk(0, 2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 1'b1,  0, 1'b1, "lock_hold"));
    run_vec(mk(0, 2'b11, 1'b1, 1'b0, 32'h0,         2'b01, 1'b1,  0, 1'b1, "lock_grant"));

    // A locked host that drops its request releases the lock in the same cycle.
    run_vec(mk(0, 2'b01, 1'b0, 1'b0, 32'h0,         2'b00, 1'b1,  0, 1'b1, "drop_lock"));
    run_vec(mk(0, 2'b10, 1'b0, 1'b0, 32'h0,         2'b00, 1'b1,  1, 1'b1, "drop_switch"));
    run_vec(mk(0, 2'b10, 1'b1, 1'b0, 32'h0,         2'b10, 1'b1,  1, 1'b1, "drop_grant"));
    run_vec(mk(0, 2'b00, 1'b0, 1'b1, 32'hF00D_0001, 2'b00, 1'b0, -1, 1'b1, "drop_rsp0"));
    run_vec(mk(0, 2'b00, 1'b0, 1'b1, 32'hF00D_0002, 2'b00, 1'b0, -1, 1'b1, "drop_rsp1"));

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_host_arbiter.md
Name: bus_host_arbiter

Overview:
- Shares one device-side request port between NrHosts bus hosts using the core req/gnt/rvalid protocol.
- Lets a second host (for example a DMA engine or debug module) reach the same RAM, SimCtrl and Timer devices as the core data port.
- Sits between the hosts and the single host slot of the address-decoding bus.
- Arbitrates round-robin, holds a stalled grant until the device accepts it, and returns in-order responses to the correct host using an outstanding-ID FIFO.

Parameters:
- NrHosts, 2, number of requesting hosts (2..8).
- DataWidth, 32, data bus width.
- AddressWidth, 32, address bus width.
- MaxOutstanding, 2, maximum accepted-but-unanswered transactions (power of 2, at least 1).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- host_req_i  in  NrHosts  per-host request.
- host_gnt_o  out  NrHosts  per-host grant (one-hot or zero).
- host_addr_i  in  NrHosts*AddressWidth  packed; host h occupies slice [h*AW +: AW].
- host_we_i  in  NrHosts  write enable.
- host_be_i  in  NrHosts*4  byte enables.
- host_wdata_i  in  NrHosts*DataWidth  write data.
- host_rvalid_o  out  NrHosts  per-host response valid.
- host_rdata_o  out  DataWidth  read data, broadcast to all hosts; qualify with host_rvalid_o.
- host_err_o  out  1  response error, broadcast; qualify with host_rvalid_o.
- dev_req_o  out  1  request to device side.
- dev_gnt_i  in  1  device accepts request.
- dev_addr_o  out  AddressWidth  muxed address.
- dev_we_o  out  1  muxed write enable.
- dev_be_o  out  4  muxed byte enables.
- dev_wdata_o  out  DataWidth  muxed write data.
- dev_rvalid_i  in  1  device response valid.
- dev_rdata_i  in  DataWidth  device read data.
- dev_err_i  in  1  device response error.
- unexp_rsp_o  out  1  sticky flag: a response arrived with no outstanding transaction.

Behaviour:
- Reset (rst_i high at a clock edge):
  - rr_ptr=0, lock_valid=0, FIFO empty (count=0), unexp_rsp_o=0.
  - While rst_i is high: host_gnt_o=0 and dev_req_o=0.
  - Reset mid-transaction discards all outstanding IDs; device responses arriving after reset set unexp_rsp_o.
- Selection (combinational):
  - If lock_valid, sel=lock_idx.
  - Otherwise sel is the first requesting host at or after rr_ptr, searching upward modulo NrHosts.
  - issue_ok = (count < MaxOutstanding) and some host_req_i is set.
- Request path:
  - dev_req_o = issue_ok.
  - dev_addr/we/be/wdata are muxed from host sel; they are don't-care when dev_req_o=0 and driven to the sel value.
  - host_gnt_o[sel] = dev_req_o & dev_gnt_i.
  - Zero-cycle pass-through: the grant appears in the same cycle as dev_gnt_i.
- Lock:
  - If dev_req_o=1 and dev_gnt_i=0: next lock_valid=1 and lock_idx=sel. No host can steal a stalled request.
  - On a grant: lock_valid clears and rr_ptr becomes (sel+1) mod NrHosts.
  - If the locked host drops host_req_i (protocol violation), lock_valid clears in that cycle and arbitration proceeds combinationally from rr_ptr.
- Outstanding FIFO:
  - Depth MaxOutstanding; each entry holds a host index of width clog2(NrHosts), minimum 1.
  - Push sel on a grant. Pop on dev_rvalid_i when count>0.
  - Push and pop may occur in the same cycle; count is unchanged.
  - Full gating uses the registered count only: when count==MaxOutstanding, dev_req_o=0 even if a pop happens that cycle. Issue resumes the next cycle.
- Response path (combinational):
  - host_rvalid_o[head] = dev_rvalid_i & (count>0).
  - host_rdata_o = dev_rdata_i; host_err_o = dev_err_i.
  - Responses are strictly in order.
- Boundary conditions:
  - dev_rvalid_i with count==0: no host_rvalid_o, no pop, unexp_rsp_o set until reset.
  - Read and write pointers wrap modulo MaxOutstanding.
  - A response returned the same cycle as the grant for that transaction is not allowed; the device latency is at least 1 cycle.
  - When no host is requesting, rr_ptr holds.

Test Plan:
- Single host: host0 reads 0x100000, device grants immediately and returns rvalid next cycle with rdata=0xDEADBEEF → host_gnt_o=01 in cycle 0, host_rvalid_o=01 with 0xDEADBEEF in cycle 1, count returns to 0.
- Fairness: both hosts request continuously with dev_gnt_i=1 and 1-cycle responses → grants alternate 01,10,01,10; the 4 responses route to hosts 0,1,0,1.
- Stall lock: rr_ptr=1, both request, dev_gnt_i=0 for 3 cycles → dev_addr_o stays host1's address (0x20000) all 3 cycles; when dev_gnt_i=1 then host_gnt_o=10 and rr_ptr=0.
- Full: MaxOutstanding=2, two grants with no response → dev_req_o=0 while count=2; after one rvalid, dev_req_o=1 on the next cycle; a simultaneous pop cycle issues nothing.
- Simultaneous push and pop: a grant to host1 and a response to host0 in the same cycle with count=1 → host_rvalid_o=01, count stays 1, and the next response goes to host1.
- Reset and unexpected response: assert rst_i with count=2, then drive dev_rvalid_i → no host_rvalid_o, unexp_rsp_o=1 until the next rst_i.
